slow_access_ctrl: RTL and testbench



---
 rtl/slow_access_ctrl_pkg.sv | 14 +
 rtl/slow_tick.sv | 39 +++
 rtl/slow_access_ctrl.sv | 115 +++++++++++
 tb/tb_slow_access_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/slow_access_ctrl_pkg.sv
// Shared definitions for the slow-access sequencer: state encoding,
// default tick divider and SlowTimeout width.
package slow_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  localparam int unsigned TICK_DIV_DEF = 16;
  localparam int unsigned TIMEOUT_W    = 4;

endpackage : slow_access_ctrl_pkg

// File: rtl/slow_tick.sv
// Hold-off prescaler: emits a one-cycle tick every TICK_DIV enabled cycles.
// A synchronous clear restarts the count and suppresses the tick that cycle.
module slow_tick
  import slow_access_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned PRE_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;

  assign tick = en && !clr && (pre_q == PRE_LAST);

  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule : slow_tick

// File: rtl/slow_access_ctrl.sv
// Slow-access sequencer: holds the CPU at stock speed during accesses to
// peripheral classes flagged slow, then for SlowTimeout prescaled ticks.
module slow_access_ctrl
  import slow_access_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned PRE_W    = 4
) (
  input  logic                 CLK,
  input  logic                 nPOR,
  input  logic                 BACT,
  input  logic                 IACKCS,
  input  logic                 VIACS,
  input  logic                 IWMCS,
  input  logic                 SCCCS,
  input  logic                 SCSICS,
  input  logic                 SndCS,
  input  logic                 SlowIACK,
  input  logic                 SlowVIA,
  input  logic                 SlowIWM,
  input  logic                 SlowSCC,
  input  logic                 SlowSCSI,
  input  logic                 SlowSnd,
  input  logic                 SlowClockGate,
  input  logic [TIMEOUT_W-1:0] SlowTimeout,
  output logic                 SlowReq,
  output logic                 ClockGateEn,
  output logic                 SlowHold
);

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] count_q, count_d;
  logic                 slow_req_q, slow_req_d;
  logic                 clk_gate_q, clk_gate_d;
  logic                 slow_hold_q, slow_hold_d;

  logic hit;
  logic tick;
  logic tick_clr;
  logic tick_en;

  assign hit = BACT && ((IACKCS && SlowIACK) || (VIACS  && SlowVIA)  ||
                        (IWMCS  && SlowIWM)  || (SCCCS  && SlowSCC)  ||
                        (SCSICS && SlowSCSI) || (SndCS  && SlowSnd));

  // Keeping the prescaler cleared outside HOLD (and on a retrigger) makes
  // every HOLD entry start a full-length count and gives Hit priority over tick.
  assign tick_clr = (state_q != ST_HOLD) || hit;
  assign tick_en  = (state_q == ST_HOLD);

  slow_tick #(
    .TICK_DIV (TICK_DIV),
    .PRE_W    (PRE_W)
  ) u_slow_tick (
    .clk   (CLK),
    .rst_n (nPOR),
    .clr   (tick_clr),
    .en    (tick_en),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hit) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!BACT) begin
          if (SlowTimeout == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
            count_d = SlowTimeout;
          end
        end
      end
      ST_HOLD: begin
        if (hit) begin
          state_d = ST_ACCESS;
        end else if (tick) begin
          count_d = count_q - 1'b1;
          if (count_q == TIMEOUT_W'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    slow_req_d  = (state_d != ST_IDLE);
    slow_hold_d = (state_d == ST_HOLD);
    clk_gate_d  = slow_req_d && SlowClockGate;
  end

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      slow_req_q  <= 1'b0;
      clk_gate_q  <= 1'b0;
      slow_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      slow_req_q  <= slow_req_d;
      clk_gate_q  <= clk_gate_d;
      slow_hold_q <= slow_hold_d;
    end
  end

  assign SlowReq     = slow_req_q;
  assign ClockGateEn = clk_gate_q;
  assign SlowHold    = slow_hold_q;

endmodule : slow_access_ctrl

// File: tb/tb_slow_access_ctrl.sv
// Directed self-checking bench for slow_access_ctrl with TICK_DIV=4.
module tb_slow_access_ctrl;

  logic       CLK = 1'b0;
  logic       nPOR;
  logic       BACT;
  logic       IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS;
  logic       SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd;
  logic       SlowClockGate;
  logic [3:0] SlowTimeout;
  logic       SlowReq, ClockGateEn, SlowHold;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  slow_access_ctrl #(
    .TICK_DIV (4),
    .PRE_W    (2)
  ) dut (
    .CLK           (CLK),
    .nPOR          (nPOR),
    .BACT          (BACT),
    .IACKCS        (IACKCS),
    .VIACS         (VIACS),
    .IWMCS         (IWMCS),
    .SCCCS         (SCCCS),
    .SCSICS        (SCSICS),
    .SndCS         (SndCS),
    .SlowIACK      (SlowIACK),
    .SlowVIA       (SlowVIA),
    .SlowIWM       (SlowIWM),
    .SlowSCC       (SlowSCC),
    .SlowSCSI      (SlowSCSI),
    .SlowSnd       (SlowSnd),
    .SlowClockGate (SlowClockGate),
    .SlowTimeout   (SlowTimeout),
    .SlowReq       (SlowReq),
    .ClockGateEn   (ClockGateEn),
    .SlowHold      (SlowHold)
  );

  // Advance one rising edge; outputs are then sampled 1ns later.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic req, input logic cge, input logic hold);
    checks++;
    assert (SlowReq === req) else begin
      errors++;
      $error("FAIL %s SlowReq observed=%b expected=%b", tag, SlowReq, req);
    end
    checks++;
    assert (ClockGateEn === cge) else begin
      errors++;
      $error("FAIL %s ClockGateEn observed=%b expected=%b", tag, ClockGateEn, cge);
    end
    checks++;
    assert (SlowHold === hold) else begin
      errors++;
      $error("FAIL %s SlowHold observed=%b expected=%b", tag, SlowHold, hold);
    end
  endtask

  task automatic clear_cs();
    IACKCS = 0; VIACS = 0; IWMCS = 0; SCCCS = 0; SCSICS = 0; SndCS = 0;
  endtask

  task automatic set_slow(input logic iack, input logic via, input logic iwm,
                          input logic scc, input logic scsi, input logic snd);
    SlowIACK = iack; SlowVIA = via; SlowIWM = iwm;
    SlowSCC = scc; SlowSCSI = scsi; SlowSnd = snd;
  endtask

  initial begin
    nPOR = 0; BACT = 0; clear_cs(); set_slow(1, 1, 1, 1, 1, 1);
    SlowClockGate = 1; SlowTimeout = 4'd3;

    // Reset state and an idle bus with every class flagged slow
    repeat (2) cyc();
    chk("reset", 0, 0, 0);
    nPOR = 1;
    IACKCS = 1; VIACS = 1; IWMCS = 1; SCCCS = 1; SCSICS = 1; SndCS = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("idle_no_bact", 0, 0, 0);
    end
    clear_cs();

    // VIA access, 2 cycles, then 12-cycle hold
    set_slow(0, 1, 0, 0, 0, 0); SlowTimeout = 4'd3; SlowClockGate = 1;
    VIACS = 1; BACT = 1;
    cyc(); chk("via_access0", 1, 1, 0);
    cyc(); chk("via_access1", 1, 1, 0);
    BACT = 0; VIACS = 0;
    cyc(); chk("via_hold_enter", 1, 1, 1);
    for (int i = 1; i < 12; i++) begin
      cyc(); chk("via_hold", 1, 1, 1);
    end
    cyc(); chk("via_hold_end", 0, 0, 0);
    cyc(); chk("via_idle", 0, 0, 0);

    // Disabled class does not hit; simultaneous enabled class does
    set_slow(0, 0, 0, 1, 0, 0); SlowTimeout = 4'd0;
    VIACS = 1; BACT = 1;
    cyc(); chk("via_disabled0", 0, 0, 0);
    cyc(); chk("via_disabled1", 0, 0, 0);
    SCCCS = 1;
    cyc(); chk("scc_hit", 1, 1, 0);
    BACT = 0; clear_cs();
    cyc(); chk("scc_end", 0, 0, 0);

    // Retrigger 5 cycles into hold; next hold is a full 8 cycles
    set_slow(0, 0, 1, 0, 0, 0); SlowTimeout = 4'd2;
    IWMCS = 1; BACT = 1;
    cyc(); chk("iwm_access", 1, 1, 0);
    BACT = 0; IWMCS = 0;
    cyc(); chk("iwm_hold_enter", 1, 1, 1);
    for (int i = 1; i < 5; i++) begin
      cyc(); chk("iwm_hold_a", 1, 1, 1);
    end
    IWMCS = 1; BACT = 1;
    cyc(); chk("iwm_retrigger", 1, 1, 0);
    BACT = 0; IWMCS = 0;
    cyc(); chk("iwm_hold2_enter", 1, 1, 1);
    for (int i = 1; i < 8; i++) begin
      cyc(); chk("iwm_hold_b", 1, 1, 1);
    end
    cyc(); chk("iwm_hold_end", 0, 0, 0);

    // Zero timeout: SlowReq high exactly for the 3-cycle access
    set_slow(0, 0, 0, 0, 1, 0); SlowTimeout = 4'd0;
    SCSICS = 1; BACT = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("scsi_access", 1, 1, 0);
    end
    BACT = 0; SCSICS = 0;
    cyc(); chk("scsi_end", 0, 0, 0);
    cyc(); chk("scsi_idle", 0, 0, 0);

    // Clock gate disabled; timeout change mid-hold is ignored
    set_slow(0, 0, 0, 0, 0, 1); SlowTimeout = 4'd3; SlowClockGate = 0;
    SndCS = 1; BACT = 1;
    cyc(); chk("snd_access0", 1, 0, 0);
    cyc(); chk("snd_access1", 1, 0, 0);
    BACT = 0; SndCS = 0;
    cyc(); chk("snd_hold_enter", 1, 0, 1);
    SlowTimeout = 4'd1;
    for (int i = 1; i < 12; i++) begin
      cyc(); chk("snd_hold", 1, 0, 1);
    end
    cyc(); chk("snd_hold_end", 0, 0, 0);

    // Asynchronous reset mid-hold, then a fresh access from idle
    SlowClockGate = 1; SlowTimeout = 4'd3;
    SndCS = 1; BACT = 1;
    cyc(); chk("rst_pre_access", 1, 1, 0);
    BACT = 0; SndCS = 0;
    cyc(); chk("rst_pre_hold", 1, 1, 1);
    cyc(); cyc();
    chk("rst_pre_hold2", 1, 1, 1);
    #2 nPOR = 0;
    #1 chk("rst_async", 0, 0, 0);
    cyc(); chk("rst_held", 0, 0, 0);
    #2 nPOR = 1;
    SlowTimeout = 4'd1; SndCS = 1; BACT = 1;
    cyc(); chk("post_rst_access", 1, 1, 0);
    BACT = 0; SndCS = 0;
    cyc(); chk("post_rst_hold", 1, 1, 1);
    for (int i = 1; i < 4; i++) begin
      cyc(); chk("post_rst_hold_n", 1, 1, 1);
    end
    cyc(); chk("post_rst_end", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_slow_access_ctrl
